// File: rtl/mod_148_4_6_plca_status_ctrl_pkg.sv
// rtl/mod_148_4_6_plca_status_ctrl_pkg.sv - shared state encodings and timer default for the PLCA status block
package mod_148_4_6_plca_status_ctrl_pkg;

  // Minimum plca_status_timer duration, in 10 Mb/s bit times.
  localparam int unsigned TIMER_BT_DEFAULT = 130090;

  typedef enum logic [1:0] {
    ST_DISABLED   = 2'd0,
    ST_INACTIVE   = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_HYSTERESIS = 2'd3
  } plca_state_e;

endpackage

// File: rtl/mod_148_4_6_status_timer.sv
// rtl/mod_148_4_6_status_timer.sv - plca_status_timer: bit-time hysteresis counter with registered done/not_done
//
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : restart the timer at count 0 (running, not expired)
//   clear      : stop the timer, count 0, both flags low (dominates start/tick)
//   tick       : one-cycle bit-time strobe, already qualified by the caller
//   done       : expired; held until the next start or clear
//   not_done   : started and not yet expired
module mod_148_4_6_status_timer
  import mod_148_4_6_plca_status_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_BT = TIMER_BT_DEFAULT,
  parameter int unsigned CNT_W    = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  input  logic tick,
  output logic done,
  output logic not_done
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMER_BT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             not_done_q, not_done_d;
  logic             advance;

  // Only a running timer counts; the LIMIT guard keeps the count saturated.
  assign advance = tick && not_done_q && (count_q != LIMIT);

  always_comb begin
    count_d    = count_q;
    done_d     = done_q;
    not_done_d = not_done_q;
    if (clear) begin
      count_d    = '0;
      done_d     = 1'b0;
      not_done_d = 1'b0;
    end else if (start) begin
      count_d    = '0;
      done_d     = 1'b0;
      not_done_d = 1'b1;
    end else if (advance) begin
      count_d = count_q + CNT_W'(1);
      // Expiry happens on the tick that reaches LIMIT; done shows one clk later.
      if (count_q == LIMIT - CNT_W'(1)) begin
        done_d     = 1'b1;
        not_done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      done_q     <= 1'b0;
      not_done_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      done_q     <= done_d;
      not_done_q <= not_done_d;
    end
  end

  assign done     = done_q;
  assign not_done = not_done_q;

endmodule

// File: rtl/mod_148_4_6_plca_status_ctrl.sv
// rtl/mod_148_4_6_plca_status_ctrl.sv - PLCA status state machine with hysteresis timer
//
// Ports:
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   bit_tick                   : one-cycle strobe per bit time
//   plca_en                    : PLCA enable; low forces DISABLED
//   plca_active                : beacon activity from the PLCA control FSM
//   plca_status                : 1 = OK, 0 = FAIL (registered)
//   plca_status_timer_done     : hysteresis timer expired
//   plca_status_timer_not_done : hysteresis timer running
//   status_chg                 : one-cycle pulse coincident with a plca_status change
//   state                      : current state code
module mod_148_4_6_plca_status_ctrl
  import mod_148_4_6_plca_status_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_BT = TIMER_BT_DEFAULT,
  parameter int unsigned CNT_W    = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_tick,
  input  logic       plca_en,
  input  logic       plca_active,
  output logic       plca_status,
  output logic       plca_status_timer_done,
  output logic       plca_status_timer_not_done,
  output logic       status_chg,
  output logic [1:0] state
);

  plca_state_e state_q, state_d;
  logic        status_q, status_d;
  logic        status_chg_q;
  logic        timer_start, timer_clear, timer_tick;
  logic        timer_done, timer_not_done;

  always_comb begin
    state_d = state_q;
    if (!plca_en) begin
      state_d = ST_DISABLED;
    end else begin
      unique case (state_q)
        ST_DISABLED:   state_d = ST_INACTIVE;
        ST_INACTIVE:   if (plca_active) state_d = ST_ACTIVE;
        ST_ACTIVE:     if (!plca_active) state_d = ST_HYSTERESIS;
        // Returning activity wins over a simultaneous expiry.
        ST_HYSTERESIS: begin
          if (plca_active)     state_d = ST_ACTIVE;
          else if (timer_done) state_d = ST_INACTIVE;
        end
        default:       state_d = ST_DISABLED;
      endcase
    end
  end

  // Timer controls are derived from the transition so the timer flags settle
  // on the same edge as the state change.
  assign timer_start = (state_d == ST_HYSTERESIS) && (state_q != ST_HYSTERESIS);
  assign timer_clear = (state_d == ST_DISABLED) ||
                       ((state_q == ST_HYSTERESIS) && (state_d == ST_ACTIVE));
  assign timer_tick  = bit_tick && (state_q == ST_HYSTERESIS);

  assign status_d = (state_d == ST_ACTIVE) || (state_d == ST_HYSTERESIS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DISABLED;
      status_q     <= 1'b0;
      status_chg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      status_chg_q <= status_d ^ status_q;
    end
  end

  mod_148_4_6_status_timer #(
    .TIMER_BT (TIMER_BT),
    .CNT_W    (CNT_W)
  ) u_status_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (timer_start),
    .clear    (timer_clear),
    .tick     (timer_tick),
    .done     (timer_done),
    .not_done (timer_not_done)
  );

  assign plca_status                = status_q;
  assign plca_status_timer_done     = timer_done;
  assign plca_status_timer_not_done = timer_not_done;
  assign status_chg                 = status_chg_q;
  assign state                      = state_q;

endmodule

// File: tb/tb_mod_148_4_6_plca_status_ctrl.sv
// tb/tb_mod_148_4_6_plca_status_ctrl.sv - scoreboard bench for the PLCA status block
module tb_mod_148_4_6_plca_status_ctrl;

  localparam int TBT = 8;

  logic       clk;
  logic       reset;
  logic       bit_tick;
  logic       plca_en;
  logic       plca_active;
  logic       plca_status;
  logic       done;
  logic       not_done;
  logic       status_chg;
  logic [1:0] state;

  mod_148_4_6_plca_status_ctrl #(
    .TIMER_BT (TBT),
    .CNT_W    (4)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .bit_tick                   (bit_tick),
    .plca_en                    (plca_en),
    .plca_active                (plca_active),
    .plca_status                (plca_status),
    .plca_status_timer_done     (done),
    .plca_status_timer_not_done (not_done),
    .status_chg                 (status_chg),
    .state                      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       status;
    logic       done;
    logic       nd;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: state number, whether a hysteresis interval is live,
  // and how many bit times have elapsed in it.
  int cyc       = 0;
  int m_state   = 0;
  bit m_live    = 0;
  int m_elapsed = 0;
  bit m_status  = 0;

  task automatic drive_cycle(input bit rst, input bit en, input bit act, input bit act_on_exp);
    bit   tk, a, done_now, new_status;
    int   ns;
    exp_t e;
    @(negedge clk);
    tk = (cyc % 4 == 3);
    cyc++;
    a = act | (act_on_exp && tk && m_state == 3 && m_live && m_elapsed == TBT - 1);
    reset       = rst;
    plca_en     = en;
    plca_active = a;
    bit_tick    = tk;
    if (rst) begin
      ns = 0; m_live = 0; m_elapsed = 0;
      new_status = 0;
      e.chg = 1'b0;
    end else begin
      done_now = m_live && (m_elapsed >= TBT);
      if (!en) ns = 0;
      else if (m_state == 0) ns = 1;
      else if (m_state == 1) ns = a ? 2 : 1;
      else if (m_state == 2) ns = a ? 2 : 3;
      else ns = a ? 2 : (done_now ? 1 : 3);
      if (ns == 0 || (m_state == 3 && ns == 2)) begin
        m_live = 0; m_elapsed = 0;
      end else if (ns == 3 && m_state != 3) begin
        m_live = 1; m_elapsed = 0;
      end else if (m_state == 3 && tk) begin
        m_elapsed++;
      end
      new_status = (ns == 2 || ns == 3);
      e.chg = (new_status != m_status);
    end
    m_state  = ns;
    m_status = new_status;
    e.st     = 2'(ns);
    e.status = new_status;
    e.done   = m_live && (m_elapsed >= TBT);
    e.nd     = m_live && (m_elapsed < TBT);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every clock the DUT presents a fresh output beat.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",      state,                e.st);
        check("plca_status", {1'b0, plca_status}, {1'b0, e.status});
        check("timer_done", {1'b0, done},         {1'b0, e.done});
        check("not_done",   {1'b0, not_done},     {1'b0, e.nd});
        check("status_chg", {1'b0, status_chg},   {1'b0, e.chg});
        if (done && not_done) begin
          errors++;
          $display("FAIL timer_flags_exclusive cycle %0d: got both 1 expected at most one", cyc);
        end
        checks++;
      end
    end
  end

  initial begin
    bit act;
    reset = 1'b1; plca_en = 1'b0; plca_active = 1'b0; bit_tick = 1'b0;
    repeat (3) drive_cycle(1, 0, 0, 0);
    repeat (2) drive_cycle(0, 1, 0, 0);           // DISABLED -> INACTIVE
    repeat (3) drive_cycle(0, 1, 1, 0);           // -> ACTIVE
    repeat (45) drive_cycle(0, 1, 0, 0);          // hysteresis expires -> INACTIVE
    repeat (3) drive_cycle(0, 1, 1, 0);
    repeat (20) drive_cycle(0, 1, 0, 0);          // 5 ticks, then activity returns
    repeat (5) drive_cycle(0, 1, 1, 0);
    repeat (40) drive_cycle(0, 1, 0, 1);          // activity on the expiring tick
    repeat (4) drive_cycle(0, 1, 1, 0);
    repeat (15) drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0);                      // enable drop mid-count
    drive_cycle(0, 1, 0, 0);
    repeat (4) drive_cycle(0, 1, 1, 0);
    repeat (15) drive_cycle(0, 1, 0, 0);
    drive_cycle(1, 1, 1, 0);                      // reset mid-count dominates
    repeat (2) drive_cycle(0, 1, 0, 0);

    act = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) act = ~act;
      drive_cycle($urandom_range(255) == 0, $urandom_range(63) != 0, act,
                  $urandom_range(1) == 1);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending beats expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
